// File: rtl/jtag_uart_bridge.sv
// JTAG-to-UART bridge: bursts JTAG words into uart_tx bytes and logs uart_rx bytes into a word RAM.
// Optional macro JTAG_UART_RX_WRAP_EN turns the rx log into a ring; otherwise logging stops when full.
module jtag_uart_bridge #(
  parameter int BYTES_PER_WORD = 4,
  parameter int RX_DEPTH_LOG2  = 11,
  parameter int SYNC_STAGES    = 2,
  localparam int DATA_W        = 8 * BYTES_PER_WORD
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     ctl_rx_en_i,
  input  logic                     ctl_tx_strobe_i,
  input  logic                     ctl_clr_i,
  input  logic [3:0]               tx_len_i,
  input  logic [DATA_W-1:0]        tx_word_i,
  output logic                     uart_tx_start_o,
  output logic [7:0]               uart_tx_data_o,
  input  logic                     uart_tx_busy_i,
  input  logic [7:0]               uart_rx_data_i,
  input  logic                     uart_rx_valid_i,
  input  logic [RX_DEPTH_LOG2-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [31:0]              status_o
);

  localparam int BSH   = $clog2(BYTES_PER_WORD);
  localparam int PTR_W = RX_DEPTH_LOG2 + BSH;
  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [PTR_W-1:0] PTR_MAX  = {PTR_W{1'b1}};
  localparam logic [PTR_W-1:0] LOW_MASK = PTR_W'((1 << BSH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} tx_state_e;

  logic [SYNC_STAGES-1:0] rx_en_sync_q, rx_en_sync_d;
  logic [SYNC_STAGES-1:0] strobe_sync_q, strobe_sync_d;
  logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
  logic                   strobe_prev_q, strobe_prev_d;
  logic                   rx_valid_prev_q, rx_valid_prev_d;

  tx_state_e              state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d, shifted;
  logic [3:0]             cnt_q, cnt_d, eff_len;
  logic                   start_q, start_d;
  logic [7:0]             txd_q, txd_d;
  logic                   coll_q, coll_d;

  logic [DATA_W-1:0]      asm_q, asm_d, asm_base;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [7:0]             last_q, last_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [31:0]            status_q, status_d;

  logic rx_en_s, strobe_s, clr_s, strobe_rise, rx_rise, accept, tx_busy, wr_en;
  logic [RX_DEPTH_LOG2-1:0] wr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rx_en_s     = rx_en_sync_q[SYNC_STAGES-1];
  assign strobe_s    = strobe_sync_q[SYNC_STAGES-1];
  assign clr_s       = clr_sync_q[SYNC_STAGES-1];
  assign strobe_rise = strobe_s & ~strobe_prev_q;
  assign rx_rise     = uart_rx_valid_i & ~rx_valid_prev_q;
  assign accept      = rx_rise & rx_en_s & ~full_q;
  assign tx_busy     = (state_q != S_IDLE) | uart_tx_busy_i;
  assign wr_en       = wr_pend_q & rx_en_s;
  assign wr_idx      = RX_DEPTH_LOG2'(ptr_q >> BSH);
  assign eff_len     = ((tx_len_i == 4'd0) || (tx_len_i > 4'(BYTES_PER_WORD))) ?
                       4'(BYTES_PER_WORD) : tx_len_i;
  assign shifted     = shift_q >> 8;

  always_comb begin
    rx_en_sync_d    = {rx_en_sync_q[SYNC_STAGES-2:0], ctl_rx_en_i};
    strobe_sync_d   = {strobe_sync_q[SYNC_STAGES-2:0], ctl_tx_strobe_i};
    clr_sync_d      = {clr_sync_q[SYNC_STAGES-2:0], ctl_clr_i};
    strobe_prev_d   = strobe_s;
    rx_valid_prev_d = uart_rx_valid_i;
  end

  // TX burst sequencer; start pulse and data are registered alongside the state
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    txd_d   = txd_q;
    coll_d  = coll_q;
    case (state_q)
      S_IDLE: if (strobe_rise) begin
        shift_d = tx_word_i;
        cnt_d   = eff_len;
        start_d = 1'b1;
        txd_d   = tx_word_i[7:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT: if (!uart_tx_busy_i) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end else begin
          shift_d = shifted;
          start_d = 1'b1;
          txd_d   = shifted[7:0];
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (strobe_rise && state_q != S_IDLE) coll_d = 1'b1;
    if (clr_s) coll_d = 1'b0;
  end

  // RX assembler: a new word starts from zero so partial words read back MSB-aligned
  always_comb begin
    asm_d     = asm_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    wr_pend_d = 1'b0;
    full_d    = full_q;
    ovf_d     = ovf_q;
    asm_base  = ((ptr_q & LOW_MASK) == '0) ? '0 : (asm_q >> 8);
    if (accept) begin
      asm_d     = asm_base | (DATA_W'(uart_rx_data_i) << (DATA_W - 8));
      last_d    = uart_rx_data_i;
      wr_pend_d = 1'b1;
    end
    if (rx_rise && rx_en_s && full_q) ovf_d = 1'b1;
    if (wr_pend_q) begin
      if (ptr_q == PTR_MAX) begin
`ifdef JTAG_UART_RX_WRAP_EN
        ptr_d = '0;
        ovf_d = 1'b1;
`else
        full_d = 1'b1;
`endif
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
    if (!rx_en_s) begin
      asm_d     = '0;
      ptr_d     = '0;
      ovf_d     = 1'b0;
      full_d    = 1'b0;
      wr_pend_d = 1'b0;
    end
    rd_data_d = mem[rd_addr_i];
    status_d  = {tx_busy, coll_q, ovf_q, rx_en_s, 4'b0, last_q, 16'(ptr_q)};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_en_sync_q    <= '0;
      strobe_sync_q   <= '0;
      clr_sync_q      <= '0;
      strobe_prev_q   <= 1'b0;
      rx_valid_prev_q <= 1'b0;
      state_q         <= S_IDLE;
      shift_q         <= '0;
      cnt_q           <= '0;
      start_q         <= 1'b0;
      txd_q           <= '0;
      coll_q          <= 1'b0;
      asm_q           <= '0;
      ptr_q           <= '0;
      last_q          <= '0;
      wr_pend_q       <= 1'b0;
      full_q          <= 1'b0;
      ovf_q           <= 1'b0;
      rd_data_q       <= '0;
      status_q        <= '0;
    end else begin
      rx_en_sync_q    <= rx_en_sync_d;
      strobe_sync_q   <= strobe_sync_d;
      clr_sync_q      <= clr_sync_d;
      strobe_prev_q   <= strobe_prev_d;
      rx_valid_prev_q <= rx_valid_prev_d;
      state_q         <= state_d;
      shift_q         <= shift_d;
      cnt_q           <= cnt_d;
      start_q         <= start_d;
      txd_q           <= txd_d;
      coll_q          <= coll_d;
      asm_q           <= asm_d;
      ptr_q           <= ptr_d;
      last_q          <= last_d;
      wr_pend_q       <= wr_pend_d;
      full_q          <= full_d;
      ovf_q           <= ovf_d;
      rd_data_q       <= rd_data_d;
      status_q        <= status_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= asm_q;
  end

  assign uart_tx_start_o = start_q;
  assign uart_tx_data_o  = txd_q;
  assign rd_data_o       = rd_data_q;
  assign status_o        = status_q;

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Directed bench for jtag_uart_bridge (4-byte words, 16-word rx RAM); uart_tx modelled as 100-cycle busy.
module tb_jtag_uart_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ctl_rx_en, ctl_tx_strobe, ctl_clr;
  logic [3:0]  tx_len;
  logic [31:0] tx_word;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] status;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int busy_cnt = 0;
  logic [7:0] got [64];

  always #5 clk = ~clk;

  jtag_uart_bridge #(.BYTES_PER_WORD(4), .RX_DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ctl_rx_en_i(ctl_rx_en), .ctl_tx_strobe_i(ctl_tx_strobe), .ctl_clr_i(ctl_clr),
    .tx_len_i(tx_len), .tx_word_i(tx_word),
    .uart_tx_start_o(tx_start), .uart_tx_data_o(tx_data), .uart_tx_busy_i(tx_busy),
    .uart_rx_data_i(rx_data), .uart_rx_valid_i(rx_valid),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .status_o(status)
  );

  // uart_tx model: logs every start pulse and stays busy 100 cycles per byte
  always @(negedge clk) begin
    if (!rstn) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      busy_cnt <= 100;
      if (pulses < 64) got[pulses] <= tx_data;
      pulses <= pulses + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = (busy_cnt != 0);

  typedef struct packed {
    logic [3:0]  len;
    logic [31:0] word;
    logic [3:0]  n;
    logic [31:0] exp;
  } tx_vec_t;
  tx_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_pulses(input int target);
    int k = 0;
    while (pulses < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (pulses < target) check("pulse_timeout", 32'(pulses), 32'(target));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (status[31] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("tx_busy_dropped", {31'b0, status[31]}, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_word(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    repeat (2) @(negedge clk);
    check(name, rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] e;
    vecs[0] = '{len: 4'd4, word: 32'h44434241, n: 4'd4, exp: 32'h44434241};
    vecs[1] = '{len: 4'd2, word: 32'h44434241, n: 4'd2, exp: 32'h00004241};
    vecs[2] = '{len: 4'd0, word: 32'h44434241, n: 4'd4, exp: 32'h44434241};
    vecs[3] = '{len: 4'd7, word: 32'hDDCCBBAA, n: 4'd4, exp: 32'hDDCCBBAA};
    vecs[4] = '{len: 4'd1, word: 32'h000000F0, n: 4'd1, exp: 32'h000000F0};
    vecs[5] = '{len: 4'd3, word: 32'h80FF0102, n: 4'd3, exp: 32'h00FF0102};

    rstn = 1'b0; ctl_rx_en = 1'b0; ctl_tx_strobe = 1'b0; ctl_clr = 1'b0;
    tx_len = 4'd0; tx_word = 32'h0; rx_data = 8'h0; rx_valid = 1'b0; rd_addr = 4'h0;
    repeat (5) @(negedge clk);
    check("reset_status", status, 32'h0);
    check("reset_start", {31'b0, tx_start}, 32'h0);
    check("reset_txdata", {24'b0, tx_data}, 32'h0);
    check("reset_rddata", rd_data, 32'h0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base = pulses;
      tx_word = vecs[i].word;
      tx_len  = vecs[i].len;
      ctl_tx_strobe = 1'b1;
      wait_pulses(base + 32'(vecs[i].n));
      repeat (3) @(negedge clk);
      wait_idle();
      ctl_tx_strobe = 1'b0;
      repeat (30) @(negedge clk);
      check($sformatf("vec%0d_count", i), 32'(pulses - base), 32'(vecs[i].n));
      e = vecs[i].exp;
      for (int j = 0; j < int'(vecs[i].n); j++)
        check($sformatf("vec%0d_byte%0d", i, j), {24'b0, got[base + j]}, {24'b0, e[8*j +: 8]});
      check($sformatf("vec%0d_nocoll", i), {31'b0, status[30]}, 32'h0);
    end

    // second strobe rise in the middle of a burst
    base = pulses;
    tx_word = 32'h44434241;
    tx_len  = 4'd4;
    ctl_tx_strobe = 1'b1;
    wait_pulses(base + 1);
    ctl_tx_strobe = 1'b0;
    repeat (5) @(negedge clk);
    tx_word = 32'h99999999;
    ctl_tx_strobe = 1'b1;
    repeat (6) @(negedge clk);
    check("coll_set", {31'b0, status[30]}, 32'h1);
    wait_pulses(base + 4);
    repeat (3) @(negedge clk);
    wait_idle();
    ctl_tx_strobe = 1'b0;
    repeat (30) @(negedge clk);
    check("coll_count", 32'(pulses - base), 32'd4);
    check("coll_b0", {24'b0, got[base]},     32'h41);
    check("coll_b3", {24'b0, got[base + 3]}, 32'h44);
    check("coll_sticky", {31'b0, status[30]}, 32'h1);
    ctl_clr = 1'b1;
    repeat (5) @(negedge clk);
    check("coll_cleared", {31'b0, status[30]}, 32'h0);
    ctl_clr = 1'b0;

    // rx logging of five bytes, including a partial word
    ctl_rx_en = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    repeat (3) @(negedge clk);
    check("rx_ptr5", {16'b0, status[15:0]}, 32'd5);
    check("rx_last", {24'b0, status[23:16]}, 32'h55);
    check("rx_en_flag", {31'b0, status[28]}, 32'h1);
    read_word(4'd1, 32'h55000000, "ram1_partial");
    rd_addr = 4'd0;
    @(posedge clk); #1;
    check("ram0_latency1", rd_data, 32'h44332211);

    // rx disabled: pointer and overflow cleared, bytes ignored
    ctl_rx_en = 1'b0;
    repeat (5) @(negedge clk);
    check("rxoff_ptr", {16'b0, status[15:0]}, 32'd0);
    check("rxoff_flag", {29'b0, status[30:28]}, 32'h0);
    send_byte(8'h99);
    repeat (3) @(negedge clk);
    check("rxoff_discard", {16'b0, status[15:0]}, 32'd0);

    // fill the 64-byte log and push one more byte
    ctl_rx_en = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 63; i++) send_byte(8'(i));
    repeat (3) @(negedge clk);
    check("fill_ptr63", {16'b0, status[15:0]}, 32'd63);
    check("fill_noovf", {31'b0, status[29]}, 32'h0);
    send_byte(8'd64);
    send_byte(8'h41);
    repeat (3) @(negedge clk);
    check("full_ovf", {31'b0, status[29]}, 32'h1);
    read_word(4'd15, 32'h403F3E3D, "ram15_last");
`ifdef JTAG_UART_RX_WRAP_EN
    check("wrap_ptr", {16'b0, status[15:0]}, 32'd1);
    read_word(4'd0, 32'h41000000, "wrap_ram0");
`else
    check("sat_ptr", {16'b0, status[15:0]}, 32'd63);
    read_word(4'd0, 32'h04030201, "sat_ram0");
`endif

    // reset in the middle of a burst
    ctl_rx_en = 1'b0;
    base = pulses;
    tx_word = 32'h44434241;
    tx_len  = 4'd4;
    ctl_tx_strobe = 1'b1;
    wait_pulses(base + 2);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    ctl_tx_strobe = 1'b0;
    #1;
    check("midrst_status", status, 32'h0);
    check("midrst_start", {31'b0, tx_start}, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (400) @(negedge clk);
    check("midrst_pulses", 32'(pulses - base), 32'd2);
    send_byte(8'h77);
    repeat (3) @(negedge clk);
    check("postrst_ptr", {16'b0, status[15:0]}, 32'd0);
    check("postrst_status", status, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
